// File: rtl/micro_seq_pkg.sv
// Shared definitions for the microprogram sequencer and the control-store encoder:
// sequencing op encodings, sequencer state and default geometry.
package micro_seq_pkg;

  localparam int unsigned DEF_AW          = 5;
  localparam int unsigned DEF_FETCH_ADDR  = 0;
  localparam int unsigned DEF_STACK_DEPTH = 2;

  typedef enum logic [2:0] {
    MOP_INC   = 3'b000,
    MOP_JMP   = 3'b001,
    MOP_JMPZ  = 3'b010,
    MOP_JMPNZ = 3'b011,
    MOP_MAP   = 3'b100,
    MOP_CALL  = 3'b101,
    MOP_RET   = 3'b110,
    MOP_HALT  = 3'b111
  } mop_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HALTED
  } useq_state_t;

endpackage

// File: rtl/micro_sequencer_if.sv
// Control-word / micro-address bundle between the control unit and the sequencer.
interface micro_sequencer_if #(
  parameter int unsigned AW = micro_seq_pkg::DEF_AW
);
  logic          start;
  logic [2:0]    mop;
  logic [AW-1:0] mtarget;
  logic          zflag;
  logic [AW-1:0] map_addr;
  logic [AW-1:0] upc;
  logic          running;
  logic          halted;
  logic          stk_err;

  modport master (
    output start, mop, mtarget, zflag, map_addr,
    input  upc, running, halted, stk_err
  );

  modport slave (
    input  start, mop, mtarget, zflag, map_addr,
    output upc, running, halted, stk_err
  );
endinterface

// File: rtl/useq_stack.sv
// Small LIFO for micro-subroutine return addresses; push on full and pop on empty
// are ignored here and reported by the caller.
module useq_stack #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);
  localparam int unsigned PW = $clog2(DEPTH + 1);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]    ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign full  = (ptr == PW'(DEPTH));
  assign empty = (ptr == '0);
  assign top   = mem[IW'(ptr - PW'(1))];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (push && !full) begin
      ptr <= ptr + PW'(1);
    end else if (pop && !empty) begin
      ptr <= ptr - PW'(1);
    end
  end

  // Entries are never cleared; only the pointer defines what is live.
  always_ff @(posedge clk) begin
    if (!clr && push && !full) begin
      mem[IW'(ptr)] <= din;
    end
  end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: registered uPC with increment/branch/dispatch/call/return
// selection and a small return stack.
module micro_sequencer
  import micro_seq_pkg::*;
#(
  parameter int unsigned AW          = DEF_AW,
  parameter int unsigned FETCH_ADDR  = DEF_FETCH_ADDR,
  parameter int unsigned STACK_DEPTH = DEF_STACK_DEPTH
) (
  input  logic                clk,
  input  logic                rst_n,
  micro_sequencer_if.slave    bus
);
  localparam logic [AW-1:0] FETCH = AW'(FETCH_ADDR);

  useq_state_t   state_q, state_n;
  logic [AW-1:0] upc_q, upc_n, upc_inc;
  logic          err_q, err_n;
  logic          running_q, halted_q;
  logic          stk_clr, stk_push, stk_pop, stk_full, stk_empty;
  logic [AW-1:0] stk_top;

  assign upc_inc = upc_q + AW'(1);

  useq_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (AW)
  ) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (stk_clr),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (upc_inc),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_comb begin
    state_n  = state_q;
    upc_n    = upc_q;
    err_n    = err_q;
    stk_clr  = 1'b0;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (bus.start) begin
          state_n = ST_RUN;
          upc_n   = FETCH;
          err_n   = 1'b0;
          stk_clr = 1'b1;
        end
      end
      ST_RUN: begin
        case (mop_t'(bus.mop))
          MOP_INC:   upc_n = upc_inc;
          MOP_JMP:   upc_n = bus.mtarget;
          MOP_JMPZ:  upc_n = bus.zflag ? bus.mtarget : upc_inc;
          MOP_JMPNZ: upc_n = bus.zflag ? upc_inc : bus.mtarget;
          MOP_MAP:   upc_n = bus.map_addr;
          MOP_CALL: begin
            upc_n = bus.mtarget;
            if (stk_full) err_n = 1'b1;
            else          stk_push = 1'b1;
          end
          MOP_RET: begin
            if (stk_empty) begin
              err_n = 1'b1;
              upc_n = FETCH;
            end else begin
              stk_pop = 1'b1;
              upc_n   = stk_top;
            end
          end
          MOP_HALT:  state_n = ST_HALTED;
          default:   upc_n = upc_inc;
        endcase
      end
      default: begin
        state_n = ST_IDLE;
        upc_n   = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      upc_q     <= FETCH;
      err_q     <= 1'b0;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_n;
      upc_q     <= upc_n;
      err_q     <= err_n;
      running_q <= (state_n == ST_RUN);
      halted_q  <= (state_n == ST_HALTED);
    end
  end

  assign bus.upc     = upc_q;
  assign bus.running = running_q;
  assign bus.halted  = halted_q;
  assign bus.stk_err = err_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench for micro_sequencer: a behavioural model predicts each cycle's outputs.
module tb_micro_sequencer;
  import micro_seq_pkg::*;

  typedef struct {
    string      tag;
    logic [4:0] upc;
    logic       run;
    logic       hlt;
    logic       err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_run;
  int   n_fail;

  exp_t       sb [$];
  int         m_st;
  logic [4:0] m_upc;
  logic       m_err;
  logic [4:0] m_stk [$];

  micro_sequencer_if #(.AW(5)) bus ();

  micro_sequencer #(
    .AW          (5),
    .FETCH_ADDR  (0),
    .STACK_DEPTH (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned act, input int unsigned exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st  = 0;
    m_upc = 5'd0;
    m_err = 1'b0;
    m_stk.delete();
  endtask

  task automatic cyc(input logic st, input logic [2:0] op, input logic [4:0] tgt,
                     input logic z, input logic [4:0] ma, input string tag);
    exp_t e;
    exp_t got;
    bus.start    = st;
    bus.mop      = op;
    bus.mtarget  = tgt;
    bus.zflag    = z;
    bus.map_addr = ma;
    if (m_st != 1) begin
      if (st) begin
        m_st  = 1;
        m_upc = 5'd0;
        m_err = 1'b0;
        m_stk.delete();
      end
    end else begin
      case (op)
        3'd0: m_upc = m_upc + 5'd1;
        3'd1: m_upc = tgt;
        3'd2: m_upc = z ? tgt : m_upc + 5'd1;
        3'd3: m_upc = !z ? tgt : m_upc + 5'd1;
        3'd4: m_upc = ma;
        3'd5: begin
          if (m_stk.size() >= 2) m_err = 1'b1;
          else m_stk.push_back(m_upc + 5'd1);
          m_upc = tgt;
        end
        3'd6: begin
          if (m_stk.size() == 0) begin
            m_err = 1'b1;
            m_upc = 5'd0;
          end else begin
            m_upc = m_stk.pop_back();
          end
        end
        default: m_st = 2;
      endcase
    end
    e.tag = tag;
    e.upc = m_upc;
    e.run = (m_st == 1);
    e.hlt = (m_st == 2);
    e.err = m_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({got.tag, ".upc"}, 32'(bus.upc), 32'(got.upc));
    chk({got.tag, ".running"}, 32'(bus.running), 32'(got.run));
    chk({got.tag, ".halted"}, 32'(bus.halted), 32'(got.hlt));
    chk({got.tag, ".stk_err"}, 32'(bus.stk_err), 32'(got.err));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".upc"}, 32'(bus.upc), 0);
    chk({tag, ".running"}, 32'(bus.running), 0);
    chk({tag, ".halted"}, 32'(bus.halted), 0);
    chk({tag, ".stk_err"}, 32'(bus.stk_err), 0);
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.start = 1'b0; bus.mop = 3'd0; bus.mtarget = 5'd0; bus.zflag = 1'b0; bus.map_addr = 5'd0;
    model_reset();
    #2;
    chk_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    cyc(1'b0, MOP_JMP, 5'd9, 1'b0, 5'd3, "idle_hold");
    cyc(1'b1, MOP_INC, 5'd0, 1'b0, 5'd0, "start");
    for (int i = 0; i < 33; i++) cyc(1'b0, MOP_INC, 5'd0, 1'b0, 5'd0, "inc");
    chk("wrap_end", 32'(bus.upc), 1);

    cyc(1'b0, MOP_MAP, 5'd0, 1'b0, 5'b10011, "map");
    chk("map_direct", 32'(bus.upc), 19);
    cyc(1'b0, MOP_JMP, 5'd28, 1'b0, 5'd0, "jmp");
    chk("jmp_direct", 32'(bus.upc), 28);

    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, MOP_JMP, 5'd4, 1'b0, 5'd0, "to4");
      cyc(1'b0, (k < 2) ? MOP_JMPZ : MOP_JMPNZ, 5'd10, (k % 2 == 0), 5'd0,
          (k < 2) ? "jmpz" : "jmpnz");
    end

    cyc(1'b0, MOP_JMP, 5'd3, 1'b0, 5'd0, "to3");
    cyc(1'b0, MOP_CALL, 5'd20, 1'b0, 5'd0, "call20");
    cyc(1'b0, MOP_CALL, 5'd25, 1'b0, 5'd0, "call25");
    chk("nest_direct", 32'(bus.upc), 25);
    cyc(1'b0, MOP_RET, 5'd0, 1'b0, 5'd0, "ret21");
    cyc(1'b0, MOP_RET, 5'd0, 1'b0, 5'd0, "ret4");
    chk("ret_direct", 32'(bus.upc), 4);
    cyc(1'b0, MOP_CALL, 5'd20, 1'b0, 5'd0, "call20b");
    cyc(1'b0, MOP_CALL, 5'd25, 1'b0, 5'd0, "call25b");
    cyc(1'b0, MOP_CALL, 5'd30, 1'b0, 5'd0, "call_full");
    cyc(1'b0, MOP_RET, 5'd0, 1'b0, 5'd0, "ret_a");
    cyc(1'b0, MOP_RET, 5'd0, 1'b0, 5'd0, "ret_b");
    cyc(1'b0, MOP_RET, 5'd0, 1'b0, 5'd0, "ret_empty");
    cyc(1'b1, MOP_INC, 5'd0, 1'b0, 5'd0, "start_in_run");

    cyc(1'b0, MOP_JMP, 5'd7, 1'b0, 5'd0, "to7");
    cyc(1'b0, MOP_HALT, 5'd0, 1'b0, 5'd0, "halt");
    cyc(1'b0, MOP_JMP, 5'd15, 1'b1, 5'd2, "halt_ign_jmp");
    cyc(1'b0, MOP_MAP, 5'd15, 1'b1, 5'd2, "halt_ign_map");
    chk("halt_direct", 32'(bus.upc), 7);
    cyc(1'b1, MOP_INC, 5'd0, 1'b0, 5'd0, "restart");
    cyc(1'b0, MOP_CALL, 5'd11, 1'b0, 5'd0, "call_after_restart");
    cyc(1'b0, MOP_RET, 5'd0, 1'b0, 5'd0, "ret_after_restart");

    cyc(1'b0, MOP_JMP, 5'd14, 1'b0, 5'd0, "to14");
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_reset_outputs("async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b0, MOP_JMP, 5'd9, 1'b1, 5'd6, "post_reset_idle");
    cyc(1'b1, MOP_JMP, 5'd9, 1'b0, 5'd0, "start2");
    cyc(1'b0, MOP_INC, 5'd9, 1'b0, 5'd0, "inc2");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Microprogram sequencer for the control unit. Holds the 5-bit micro-program counter (uPC) that addresses the control store. Each cycle it selects the next uPC from increment, branch target, conditional branch, opcode-mapper dispatch address, or a 2-deep return stack. It sits directly downstream of the opcode mapper, consuming its 5-bit first-microinstruction address, and directly upstream of the control store ROM.

## Interface
- AW, 5, micro-address width
- FETCH_ADDR, 0, address of the fetch microroutine; restart and underflow target
- STACK_DEPTH, 2, return-stack entries
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  begin/restart microprogram execution
- mop  input  3  sequencing op field of the current control word
- mtarget  input  AW  branch/call target field of the current control word
- zflag  input  1  ALU zero flag, valid during the current cycle
- map_addr  input  AW  dispatch address from the opcode mapper, stable before rising edge
- upc  output  AW  current micro-address to the control store
- running  output  1  state == RUN
- halted  output  1  state == HALTED
- stk_err  output  1  sticky stack overflow/underflow flag

## Operation
- States: IDLE, RUN, HALTED. IDLE -start-> RUN. RUN -HALT op-> HALTED. HALTED -start-> RUN.
- IDLE: upc held at FETCH_ADDR, mop ignored.
- Entering RUN from IDLE or HALTED: upc <= FETCH_ADDR, stack pointer cleared, stk_err cleared. start in RUN is ignored.
- RUN, per mop (3'b):
  - 000 INC: upc+1, wraps 31 -> 0.
  - 001 JMP: mtarget.
  - 010 JMPZ: mtarget if zflag=1, else upc+1.
  - 011 JMPNZ: mtarget if zflag=0, else upc+1.
  - 100 MAP: map_addr.
  - 101 CALL: push upc+1 (wrapped), go to mtarget.
    - If the stack is full: stk_err<=1, stack unchanged, still go to mtarget.
  - 110 RET: pop, go to popped value.
    - If the stack is empty: stk_err<=1, go to FETCH_ADDR.
  - 111 HALT: upc holds, state -> HALTED.
- HALTED: upc holds, mop ignored.
- stk_err is sticky; it clears only on reset or on a start transition into RUN.
- Stack is LIFO. Pointer ranges 0..STACK_DEPTH. Entries are not cleared on pop.

## Timing
- Reset (asynchronous, any time including mid-microroutine):
  - upc=FETCH_ADDR, state=IDLE, running=0, halted=0, stk_err=0, stack pointer=0.
- upc is registered. The control store reads combinationally from upc. The next upc is computed combinationally from mop/mtarget/zflag/map_addr and loads on the next rising edge.
- One microinstruction per cycle; branch, dispatch and return each have 1-cycle latency.
- The mapper drives map_addr from the falling edge. The sequencer samples it only at the rising edge; no extra handshake.
- start is level-sampled at the rising edge. The first RUN cycle presents FETCH_ADDR on upc.
- running and halted are registered, derived from state, and change on the same edge as the state.

## Structure
- Shared package micro_seq_pkg:
  - mop encodings (MOP_INC … MOP_HALT).
  - state enum.
  - AW and FETCH_ADDR defaults.
  - The package is reused by the control-store encoder.
- Sub-module useq_stack:
  - Parameterised LIFO (depth, width).
  - push/pop inputs; full/empty and top outputs.
  - Asynchronous active-low reset of the pointer.
- Next-address mux stays in micro_sequencer.

## Test plan
- Reset, then start with mop=INC for 33 cycles: upc=0,1,…,31,0,1. running=1.
- MAP dispatch with map_addr=5'b10011: upc=19 on the next edge. Then JMP mtarget=28: upc=28.
- JMPZ mtarget=10 at upc=4:
  - zflag=1 -> upc=10.
  - zflag=0 -> upc=5.
  - JMPNZ gives the mirrored results.
- Nested calls:
  - CALL 20 at upc=3, then CALL 25 at upc=20 -> upc=25.
  - RET -> 21, RET -> 4.
  - A third CALL with the stack full sets stk_err=1 and upc=target.
  - RET on an empty stack -> upc=0, stk_err=1.
- HALT at upc=7:
  - upc stays 7, halted=1, mop changes ignored.
  - start -> upc=0, running=1, stk_err=0.
- Assert rst_n low asynchronously mid-cycle during RUN at upc=14:
  - upc=0, IDLE, and all outputs zero immediately, without a clock edge.
  - After release, no activity until start.
